exma_pipe: RTL
==============

EXMA_PIPE -- requirements
Module: exma_pipe

Interface
REQ-001 The block SHALL expose exactly the following ports:
  s_clk_i  in  1  clock, all state on rising edge.
  s_resetn_i  in  1  reset, synchronous, active-low.
  s_flush_i  in  1  flush request from MA stage.
  s_ma_stall_i  in  1  MA stage cannot accept a new instruction this cycle.
  s_ex_valid_i  in  1  EX stage holds a valid instruction.
  s_ex_ictrl_i  in  ictrl  instruction control of the EX instruction.
  s_ex_rd_i  in  5  destination register index.
  s_exe_finished_i  in  1  executor multicycle unit (MDU/CMU) has finished.
  s_exe_result_i  in  32  executor result.
  s_ex_stall_o  out  1  holds OP/EX register and executor operands.
  s_ma_valid_o  out  1  EX/MA register holds a valid instruction.
  s_ma_ictrl_o  out  ictrl  registered instruction control.
  s_ma_rd_o  out  5  registered destination index.
  s_ma_result_o  out  32  registered result.
  s_ex_timeout_o  out  1  one-cycle pulse: multicycle watchdog expired.
  s_ma_rpar_o  out  1  result parity (EXMA_PARITY_EN only).
  s_ma_perr_o  out  1  stored-result parity error (EXMA_PARITY_EN only).
REQ-002 Multicycle instruction SHALL mean s_ex_valid_i & (ictrl[ICTRL_UNIT_MDU] | ictrl[ICTRL_UNIT_CMU]).

Function
REQ-003 FSM states SHALL be IDLE, WAIT (multicycle running), HOLD (result ready, MA stalled).
REQ-004 IDLE: a valid single-cycle instruction with s_ma_stall_i=0 SHALL be captured at the next edge (latency 1).
REQ-005 IDLE: a valid single-cycle instruction with s_ma_stall_i=1 SHALL assert s_ex_stall_o and leave the EX/MA register unchanged.
REQ-006 IDLE: a multicycle instruction with s_exe_finished_i=0 SHALL assert s_ex_stall_o combinationally and go to WAIT.
REQ-007 WAIT: s_ex_stall_o=1; on s_exe_finished_i=1 with s_ma_stall_i=0 the block SHALL capture the result and go to IDLE; with s_ma_stall_i=1 it SHALL go to HOLD.
REQ-008 HOLD: s_ex_stall_o=1; the executor result SHALL be buffered internally on entry; when s_ma_stall_i=0 the buffer SHALL be captured and the FSM SHALL return to IDLE.
REQ-009 While s_ma_stall_i=1 all EX/MA register outputs SHALL hold their values.
REQ-010 Without capture and without MA stall, s_ma_valid_o SHALL drop to 0 (bubble).
REQ-011 s_flush_i SHALL win over every other event: next cycle s_ma_valid_o=0, FSM=IDLE, watchdog cleared; s_ex_stall_o=0 in the flush cycle.
REQ-012 Watchdog: a 6-bit counter SHALL increment each WAIT cycle and clear on leaving WAIT; at count 40 the block SHALL pulse s_ex_timeout_o, inject a bubble, and return to IDLE.
REQ-013 Simultaneous s_exe_finished_i and watchdog expiry SHALL be treated as finished (no timeout).

Reset
REQ-014 While s_resetn_i=0 at an edge: FSM=IDLE, counter=0, s_ma_valid_o=0, s_ma_ictrl_o=0, s_ma_rd_o=0, s_ma_result_o=0, s_ex_timeout_o=0, s_ma_rpar_o=0, s_ma_perr_o=0.
REQ-015 Reset during WAIT or HOLD SHALL discard the buffered result.

Configuration
REQ-016 Macro EXMA_PARITY_EN defined: even parity of s_ma_result_o SHALL be stored with every capture; s_ma_perr_o SHALL be the combinational mismatch between the stored parity and the recomputed parity.
REQ-017 Macro EXMA_PARITY_EN undefined: s_ma_rpar_o and s_ma_perr_o SHALL be tied to 0 and no parity flop SHALL exist.

Structure
REQ-018 FSM state enum, the watchdog limit (40), and its width SHALL live in p_hardisc.
REQ-019 The watchdog SHALL be a sub-module exma_watchdog (enable, clear, expire).

Verification
REQ-020 ADD with rd=5, result 0x0000_0010, no stall -> next cycle s_ma_valid_o=1, s_ma_rd_o=5, s_ma_result_o=0x10, s_ex_stall_o never asserted.
REQ-021 MUL, finished after 3 cycles, result 0xDEAD_BEEF -> s_ex_stall_o high 3 cycles, capture on the 4th edge, s_ma_result_o=0xDEADBEEF.
REQ-022 DIV finishes while s_ma_stall_i=1 for 2 cycles -> HOLD for 2 cycles, result preserved, captured when the stall drops.
REQ-023 Flush in the 2nd WAIT cycle -> next cycle s_ma_valid_o=0, FSM=IDLE, no timeout.
REQ-024 MDU never finishes -> s_ex_timeout_o pulse after 40 WAIT cycles, bubble, IDLE.
REQ-025 With EXMA_PARITY_EN, capture 0x0000_0007 -> s_ma_rpar_o=1; a forced bit flip in the stored result -> s_ma_perr_o=1.

Source files
------------

// File: rtl/exma_pipe_pkg.sv
// Shared EX/MA definitions: instruction control layout, FSM states
// and multicycle watchdog limit.
package p_hardisc;

    localparam int ICTRL_W         = 8;
    localparam int ICTRL_UNIT_ALU  = 0;
    localparam int ICTRL_UNIT_MDU  = 1;
    localparam int ICTRL_UNIT_CMU  = 2;
    localparam int ICTRL_UNIT_LSU  = 3;

    typedef logic [ICTRL_W-1:0] ictrl;

    localparam int                WDOG_W     = 6;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = 6'd40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } exma_state_t;

    function automatic logic is_multi(input ictrl c);
        return c[ICTRL_UNIT_MDU] | c[ICTRL_UNIT_CMU];
    endfunction

endpackage

// File: rtl/exma_pipe_watchdog.sv
// Multicycle watchdog: counts enabled cycles, flags expiry on the
// cycle that would reach WDOG_LIMIT.
module exma_watchdog
    import p_hardisc::*;
(
    input  logic s_clk_i,
    input  logic s_resetn_i,
    input  logic s_enable_i,
    input  logic s_clear_i,
    output logic s_expire_o
);

    logic [WDOG_W-1:0] r_cnt;

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i || s_clear_i) begin
            r_cnt <= '0;
        end else if (s_enable_i) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign s_expire_o = s_enable_i
                      & (r_cnt == WDOG_LIMIT - 1'b1);

endmodule

// File: rtl/exma_pipe.sv
// EX/MA pipeline register with multicycle wait/hold FSM and watchdog.
// Optional result parity: define EXMA_PARITY_EN.
module exma_pipe
    import p_hardisc::*;
(
    input  logic               s_clk_i,
    input  logic               s_resetn_i,
    input  logic               s_flush_i,
    input  logic               s_ma_stall_i,
    input  logic               s_ex_valid_i,
    input  logic [ICTRL_W-1:0] s_ex_ictrl_i,
    input  logic [4:0]         s_ex_rd_i,
    input  logic               s_exe_finished_i,
    input  logic [31:0]        s_exe_result_i,
    output logic               s_ex_stall_o,
    output logic               s_ma_valid_o,
    output logic [ICTRL_W-1:0] s_ma_ictrl_o,
    output logic [4:0]         s_ma_rd_o,
    output logic [31:0]        s_ma_result_o,
    output logic               s_ex_timeout_o,
    output logic               s_ma_rpar_o,
    output logic               s_ma_perr_o
);

    exma_state_t        r_state;
    logic               r_ma_valid;
    logic [ICTRL_W-1:0] r_ma_ictrl;
    logic [4:0]         r_ma_rd;
    logic [31:0]        r_ma_result;
    logic [31:0]        r_buf;
    logic               r_timeout;

    exma_state_t        w_nxt;
    logic               w_multi;
    logic               w_stall;
    logic               w_cap;
    logic               w_buf_ld;
    logic               w_tmo;
    logic               w_expire;
    logic               w_wd_clr;
    logic [31:0]        w_res;

    assign w_multi = s_ex_valid_i & is_multi(s_ex_ictrl_i);

    always_comb begin
        w_nxt    = r_state;
        w_stall  = 1'b0;
        w_cap    = 1'b0;
        w_buf_ld = 1'b0;
        w_tmo    = 1'b0;
        w_res    = s_exe_result_i;
        if (s_flush_i) begin
            w_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_multi && !s_exe_finished_i) begin
                        w_stall = 1'b1;
                        w_nxt   = ST_WAIT;
                    end else if (s_ex_valid_i && s_ma_stall_i) begin
                        w_stall = 1'b1;
                        // a finished multicycle result must survive the stall
                        if (w_multi) begin
                            w_nxt    = ST_HOLD;
                            w_buf_ld = 1'b1;
                        end
                    end else if (s_ex_valid_i) begin
                        w_cap = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (s_exe_finished_i && s_ma_stall_i) begin
                        w_stall  = 1'b1;
                        w_nxt    = ST_HOLD;
                        w_buf_ld = 1'b1;
                    end else if (s_exe_finished_i) begin
                        w_cap = 1'b1;
                        w_nxt = ST_IDLE;
                    end else if (w_expire) begin
                        w_tmo = 1'b1;
                        w_nxt = ST_IDLE;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
                ST_HOLD: begin
                    w_res = r_buf;
                    if (s_ma_stall_i) begin
                        w_stall = 1'b1;
                    end else begin
                        w_cap = 1'b1;
                        w_nxt = ST_IDLE;
                    end
                end
                default: w_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_wd_clr = s_flush_i | (w_nxt != ST_WAIT);

    exma_watchdog u_wdog (
        .s_clk_i    (s_clk_i),
        .s_resetn_i (s_resetn_i),
        .s_enable_i (r_state == ST_WAIT),
        .s_clear_i  (w_wd_clr),
        .s_expire_o (w_expire)
    );

`ifdef EXMA_PARITY_EN
    logic r_rpar;
`endif

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            r_state     <= ST_IDLE;
            r_ma_valid  <= 1'b0;
            r_ma_ictrl  <= '0;
            r_ma_rd     <= '0;
            r_ma_result <= '0;
            r_buf       <= '0;
            r_timeout   <= 1'b0;
`ifdef EXMA_PARITY_EN
            r_rpar      <= 1'b0;
`endif
        end else begin
            r_state   <= w_nxt;
            r_timeout <= w_tmo;
            if (w_buf_ld) begin
                r_buf <= s_exe_result_i;
            end
            if (s_flush_i) begin
                r_ma_valid <= 1'b0;
            end else if (!s_ma_stall_i) begin
                r_ma_valid <= w_cap;
                if (w_cap) begin
                    r_ma_ictrl  <= s_ex_ictrl_i;
                    r_ma_rd     <= s_ex_rd_i;
                    r_ma_result <= w_res;
`ifdef EXMA_PARITY_EN
                    r_rpar      <= ^w_res;
`endif
                end
            end
        end
    end

    assign s_ex_stall_o   = w_stall;
    assign s_ma_valid_o   = r_ma_valid;
    assign s_ma_ictrl_o   = r_ma_ictrl;
    assign s_ma_rd_o      = r_ma_rd;
    assign s_ma_result_o  = r_ma_result;
    assign s_ex_timeout_o = r_timeout;

`ifdef EXMA_PARITY_EN
    assign s_ma_rpar_o = r_rpar;
    assign s_ma_perr_o = r_rpar ^ (^r_ma_result);
`else
    assign s_ma_rpar_o = 1'b0;
    assign s_ma_perr_o = 1'b0;
`endif

endmodule
